// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port indices,
// default memory placement and the address range helpers.
package dmem_pkg;

    localparam logic [1:0]  ST_IDLE            = 2'd0;
    localparam logic [1:0]  ST_ACCESS          = 2'd1;
    localparam logic [1:0]  ST_RESP            = 2'd2;

    localparam logic        PORT_CPU           = 1'b0;
    localparam logic        PORT_DBG           = 1'b1;

    localparam logic [31:0] DMEM_BASE_DEFAULT  = 32'h0000_1000;
    localparam int          DEPTH_LOG2_DEFAULT = 14;

    localparam logic [3:0]  WAIT_CNT_SAT       = 4'd15;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // Byte offset from the memory base; bit 32 set means the address lies below the base.
    function automatic logic [32:0] dmem_offset(input logic [31:0] addr, input logic [31:0] base);
        return {1'b0, addr & 32'hFFFF_FFFC} - {1'b0, base};
    endfunction

    function automatic logic dmem_in_range(input logic [32:0] offset, input int depth_log2);
        logic [32:0] limit;
        limit = 33'd4 << depth_log2;
        return (offset[32] == 1'b0) && (offset < limit);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the two data-memory requesters. Default build: fixed
// priority with a starvation counter; DMEM_ARB_ROUND_ROBIN_EN selects round robin.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic decide,
    input  logic cpu_req,
    input  logic dbg_req,
    output logic grant_valid,
    output logic grant_port
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN

    logic rr_r;

    // Ties go to whichever port did not win the previous grant.
    always_comb begin
        grant_valid = cpu_req | dbg_req;
        if (cpu_req && dbg_req) begin
            grant_port = rr_r ? PORT_DBG : PORT_CPU;
        end else if (dbg_req) begin
            grant_port = PORT_DBG;
        end else begin
            grant_port = PORT_CPU;
        end
    end

    // Pointer holds 1 when the debug port owns the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_r <= 1'b0;
        end else if (decide && grant_valid) begin
            rr_r <= (grant_port == PORT_CPU);
        end else begin
            rr_r <= rr_r;
        end
    end

`else

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_r;
    logic       starved_s;

    // CPU wins ties unless the debug port has lost MAX_WAIT decisions in a row.
    always_comb begin
        starved_s   = (wait_cnt_r >= MAX_WAIT_C);
        grant_valid = cpu_req | dbg_req;
        if (dbg_req && (!cpu_req || starved_s)) begin
            grant_port = PORT_DBG;
        end else begin
            grant_port = PORT_CPU;
        end
    end

    // Count consecutive debug losses; only IDLE decisions move the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 4'd0;
        end else if (decide) begin
            if (!dbg_req || (grant_port == PORT_DBG)) begin
                wait_cnt_r <= 4'd0;
            end else if (wait_cnt_r != WAIT_CNT_SAT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data SPRAM between the CPU load/store port and the debug
// port; one transaction per three cycles. Arbitration policy follows DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEFAULT,
    parameter int          DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int          MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_err,
    output logic                  cpu_stall,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [31:0]           dbg_addr,
    input  logic [31:0]           dbg_wdata,
    input  logic [3:0]            dbg_be,
    output logic [31:0]           dbg_rdata,
    output logic                  dbg_ack,
    output logic                  dbg_err,

    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  mem_we,
    output logic                  mem_cs,
    input  logic [31:0]           mem_rdata
);

    logic                  decide_s;
    logic                  grant_valid_s;
    logic                  grant_port_s;
    dmem_req_t             sel_req_s;
    logic [32:0]           offset_s;
    logic                  in_range_s;
    logic [DEPTH_LOG2-1:0] word_idx_s;

    logic [1:0]            state_r;
    logic                  winner_r;
    logic                  in_range_r;
    logic                  rd_r;

    logic [DEPTH_LOG2-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic [3:0]            mem_be_r;
    logic                  mem_we_r;
    logic                  mem_cs_r;

    logic                  cpu_ack_r;
    logic                  cpu_err_r;
    logic                  cpu_rsel_r;
    logic                  dbg_ack_r;
    logic                  dbg_err_r;
    logic                  dbg_rsel_r;

    assign decide_s = (state_r == ST_IDLE);

    dmem_arb_pick #(
        .MAX_WAIT    (MAX_WAIT)
    ) u_pick (
        .clk         (clk),
        .reset_n     (reset_n),
        .decide      (decide_s),
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s)
    );

    // Select the winning port's request and translate its byte address to a word index.
    always_comb begin
        if (grant_port_s == PORT_DBG) begin
            sel_req_s = {dbg_we, dbg_addr, dbg_wdata, dbg_be};
        end else begin
            sel_req_s = {cpu_we, cpu_addr, cpu_wdata, cpu_be};
        end
        offset_s   = dmem_offset(sel_req_s.addr, DMEM_BASE);
        in_range_s = dmem_in_range(offset_s, DEPTH_LOG2);
        word_idx_s = offset_s[DEPTH_LOG2+1:2];
    end

    // IDLE -> ACCESS -> RESP: the memory strobe is registered at grant so it is
    // live during ACCESS, and the ack is registered on leaving ACCESS so it lines
    // up with the SPRAM's one-cycle read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            winner_r    <= PORT_CPU;
            in_range_r  <= 1'b0;
            rd_r        <= 1'b0;
            mem_addr_r  <= {DEPTH_LOG2{1'b0}};
            mem_wdata_r <= 32'h0;
            mem_be_r    <= 4'b0000;
            mem_we_r    <= 1'b0;
            mem_cs_r    <= 1'b0;
            cpu_ack_r   <= 1'b0;
            cpu_err_r   <= 1'b0;
            cpu_rsel_r  <= 1'b0;
            dbg_ack_r   <= 1'b0;
            dbg_err_r   <= 1'b0;
            dbg_rsel_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        state_r     <= ST_ACCESS;
                        winner_r    <= grant_port_s;
                        in_range_r  <= in_range_s;
                        rd_r        <= ~sel_req_s.we;
                        mem_cs_r    <= in_range_s;
                        mem_we_r    <= in_range_s & sel_req_s.we;
                        mem_addr_r  <= in_range_s ? word_idx_s : {DEPTH_LOG2{1'b0}};
                        mem_wdata_r <= in_range_s ? sel_req_s.wdata : 32'h0;
                        mem_be_r    <= (in_range_s && sel_req_s.we) ? sel_req_s.be : 4'b0000;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_RESP;
                    mem_cs_r    <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= {DEPTH_LOG2{1'b0}};
                    mem_wdata_r <= 32'h0;
                    mem_be_r    <= 4'b0000;
                    cpu_ack_r   <= (winner_r == PORT_CPU);
                    dbg_ack_r   <= (winner_r == PORT_DBG);
                    cpu_err_r   <= (winner_r == PORT_CPU) & ~in_range_r;
                    dbg_err_r   <= (winner_r == PORT_DBG) & ~in_range_r;
                    cpu_rsel_r  <= (winner_r == PORT_CPU) & in_range_r & rd_r;
                    dbg_rsel_r  <= (winner_r == PORT_DBG) & in_range_r & rd_r;
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    cpu_ack_r  <= 1'b0;
                    dbg_ack_r  <= 1'b0;
                    cpu_err_r  <= 1'b0;
                    dbg_err_r  <= 1'b0;
                    cpu_rsel_r <= 1'b0;
                    dbg_rsel_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_cs_r    <= 1'b0;
                    mem_we_r    <= 1'b0;
                    mem_be_r    <= 4'b0000;
                    cpu_ack_r   <= 1'b0;
                    dbg_ack_r   <= 1'b0;
                    cpu_err_r   <= 1'b0;
                    dbg_err_r   <= 1'b0;
                    cpu_rsel_r  <= 1'b0;
                    dbg_rsel_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read data comes straight from the SPRAM, gated by the registered select.
    assign cpu_rdata = cpu_rsel_r ? mem_rdata : 32'h0;
    assign dbg_rdata = dbg_rsel_r ? mem_rdata : 32'h0;
    assign cpu_ack   = cpu_ack_r;
    assign cpu_err   = cpu_err_r;
    assign dbg_ack   = dbg_ack_r;
    assign dbg_err   = dbg_err_r;
    assign cpu_stall = cpu_req & ~cpu_ack_r;

    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign mem_we    = mem_we_r;
    assign mem_cs    = mem_cs_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural SPRAM, word-level reference
// memory, directed and randomized transactions on both ports.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DL2   = 14;
    localparam int          WORDS = 1 << DL2;
    localparam int          MAXW  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]   cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic [3:0]    cpu_be = 4'h0;
    logic [31:0]   cpu_rdata;
    logic          cpu_ack, cpu_err, cpu_stall;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0]   dbg_addr = 32'h0, dbg_wdata = 32'h0;
    logic [3:0]    dbg_be = 4'h0;
    logic [31:0]   dbg_rdata;
    logic          dbg_ack, dbg_err;
    logic [DL2-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_we, mem_cs;
    logic [31:0]   mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int double_ack_cnt = 0;
    int spurious_cnt = 0;
    bit cpu_busy = 1'b0;
    bit dbg_busy = 1'b0;

    logic [31:0] spram [0:WORDS-1] = '{default: 32'h0};
    logic [31:0] ref_mem [int];

    dmem_arbiter #(.DMEM_BASE(BASE), .DEPTH_LOG2(DL2), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
        .mem_cs(mem_cs), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SPRAM: byte-masked write, registered read
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) spram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= spram[mem_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_ack && dbg_ack) double_ack_cnt <= double_ack_cnt + 1;
        if ((cpu_ack && !cpu_busy) || (dbg_ack && !dbg_busy)) spurious_cnt <= spurious_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic bit ref_in_range(input logic [31:0] a);
        longint unsigned w;
        w = longint'(a) & 64'hFFFF_FFFC;
        return (w >= longint'(BASE)) && (w < longint'(BASE) + 4 * WORDS);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'(((longint'(a) & 64'hFFFF_FFFC) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] ref_read(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 32'h0;
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (!ref_in_range(a)) return;
        w = ref_read(ref_idx(a));
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[ref_idx(a)] = w;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with the arbiter idle; returns at the falling edge after the ack.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input bit drop,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output bit cs_seen, output logic [DL2-1:0] cs_addr,
                          output bit stall_ok, output bit one_pulse);
        logic ack;
        lat = -1; cs_seen = 1'b0; cs_addr = '0; stall_ok = 1'b1; one_pulse = 1'b0;
        rdata = 32'h0; err = 1'b0;
        if (port == 1'b0) begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be; cpu_req = 1'b1; cpu_busy = 1'b1;
        end else begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_be = be; dbg_req = 1'b1; dbg_busy = 1'b1;
        end
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (mem_cs) begin cs_seen = 1'b1; cs_addr = mem_addr; end
            if (drop && i == 1) begin cpu_req = 1'b0; dbg_req = 1'b0; end
            ack = port ? dbg_ack : cpu_ack;
            if (ack) begin
                lat = i;
                rdata = port ? dbg_rdata : cpu_rdata;
                err = port ? dbg_err : cpu_err;
                if (port == 1'b0 && cpu_stall) stall_ok = 1'b0;
            end else if (port == 1'b0 && !drop && !cpu_stall) begin
                stall_ok = 1'b0;
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        one_pulse = !(cpu_ack || dbg_ack);
        cpu_busy = 1'b0; dbg_busy = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_busy = 1'b0; dbg_busy = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        cpu_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_addr, mem_wdata,
             mem_be, mem_we, mem_cs} !== 120'd0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        checks++;
        if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi: got %b want 1", cpu_stall); end
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", cpu_stall); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        do_txn(1'b0, 1'b1, 32'h1004, 32'hA5A5_1234, 4'hF, 1'b0, rd, er, lat, cs, ca, st, op);
        ref_write(32'h1004, 32'hA5A5_1234, 4'hF);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
        checks++; if (ca !== 14'd1 || !cs) begin errors++; $display("FAIL wr_mem_addr: got %0d cs %b want 1", ca, cs); end
        checks++; if (er !== 1'b0 || !op || !st) begin errors++; $display("FAIL wr_status: err %b pulse %b stall %b want 0 1 1", er, op, st); end
        do_txn(1'b0, 1'b0, 32'h1004, 32'h0, 4'h0, 1'b0, rd, er, lat, cs, ca, st, op);
        checks++; if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL rd_data: got %h want a5a51234", rd); end
        checks++; if (lat !== 2 || ca !== 14'd1 || er !== 1'b0) begin errors++; $display("FAIL rd_status: lat %0d addr %0d err %b want 2 1 0", lat, ca, er); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        do_txn(1'b0, 1'b1, 32'h1010, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er, lat, cs, ca, st, op);
        ref_write(32'h1010, 32'hFFFF_FFFF, 4'hF);
        do_txn(1'b1, 1'b1, 32'h1010, 32'h0000_7700, 4'b0010, 1'b0, rd, er, lat, cs, ca, st, op);
        ref_write(32'h1010, 32'h0000_7700, 4'b0010);
        do_txn(1'b0, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, rd, er, lat, cs, ca, st, op);
        checks++; if (rd !== 32'hFFFF_77FF) begin errors++; $display("FAIL byte_write: got %h want ffff77ff", rd); end
        // zero mask: cycle issued, memory unchanged
        do_txn(1'b1, 1'b1, 32'h1010, 32'h1234_5678, 4'b0000, 1'b0, rd, er, lat, cs, ca, st, op);
        checks++; if (!cs || lat !== 2 || er !== 1'b0) begin errors++; $display("FAIL zero_be_cycle: cs %b lat %0d err %b want 1 2 0", cs, lat, er); end
        do_txn(1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, rd, er, lat, cs, ca, st, op);
        checks++; if (rd !== 32'hFFFF_77FF) begin errors++; $display("FAIL zero_be_data: got %h want ffff77ff", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        logic [31:0] addrs [3];
        bit          exp_in [3];
        addrs[0] = 32'h0000_0FFC; addrs[1] = 32'h0001_1000; addrs[2] = 32'h0001_0FFC;
        exp_in[0] = 1'b0; exp_in[1] = 1'b0; exp_in[2] = 1'b1;
        ref_write(32'h0001_0FFC, 32'hC0DE_0001, 4'hF);
        do_txn(1'b1, 1'b1, 32'h0001_0FFC, 32'hC0DE_0001, 4'hF, 1'b0, rd, er, lat, cs, ca, st, op);
        for (int k = 0; k < 3; k++) begin
            do_txn(1'b0, 1'b0, addrs[k], 32'h0, 4'h0, 1'b0, rd, er, lat, cs, ca, st, op);
            checks++;
            if (cs !== exp_in[k] || er !== !exp_in[k] || lat !== 2 ||
                rd !== (exp_in[k] ? 32'hC0DE_0001 : 32'h0)) begin
                errors++;
                $display("FAIL range_%0d: addr %h cs %b err %b lat %0d rdata %h want cs %b err %b",
                         k, addrs[k], cs, er, lat, rd, exp_in[k], !exp_in[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        bit port, we, drop, inr; logic [3:0] be; int r;
        for (int n = 0; n < 60; n++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0);
            be   = 4'($urandom_range(0, 15));
            wd   = $urandom;
            r    = $urandom_range(0, 9);
            if (r < 6)       addr = BASE + 32'(4 * $urandom_range(0, 15));
            else if (r == 6) addr = BASE + 32'(4 * (WORDS - 1));
            else if (r == 7) addr = BASE - 32'(4 * $urandom_range(1, 1024));
            else if (r == 8) addr = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 1000));
            else             addr = $urandom;
            addr = addr | 32'($urandom_range(0, 3));
            inr = ref_in_range(addr);
            exp_rd = (inr && !we) ? ref_read(ref_idx(addr)) : 32'h0;
            do_txn(port, we, addr, wd, be, drop, rd, er, lat, cs, ca, st, op);
            if (we) ref_write(addr, wd, be);
            checks++;
            if (rd !== exp_rd || er !== !inr || lat !== 2 || !op || cs !== inr ||
                (inr && ca !== DL2'(ref_idx(addr)))) begin
                errors++;
                $display("FAIL rand_%0d: port %0d we %b addr %h rdata %h err %b lat %0d cs %b maddr %0d want rdata %h err %b",
                         n, port, we, addr, rd, er, lat, cs, ca, exp_rd, !inr);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, exp_rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        int acks;
        exp_rd = ref_read(2);
        cpu_we = 1'b1; cpu_addr = 32'h1008; cpu_wdata = 32'hDEAD_BEEF; cpu_be = 4'hF;
        cpu_req = 1'b1; cpu_busy = 1'b1;
        @(negedge clk);
        checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL abort_access: cs %b we %b want 1 1", mem_cs, mem_we); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_addr, mem_wdata,
             mem_be, mem_we, mem_cs} !== 120'd0 || cpu_stall !== 1'b1) begin
            errors++; $display("FAIL abort_outputs: outputs not cleared, stall %b", cpu_stall);
        end
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ack || dbg_ack) acks++;
        end
        cpu_req = 1'b0; cpu_busy = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        if (cpu_ack || dbg_ack) acks++;
        checks++; if (acks !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
        do_txn(1'b0, 1'b0, 32'h1008, 32'h0, 4'h0, 1'b0, rd, er, lat, cs, ca, st, op);
        checks++;
        if (rd !== exp_rd || lat !== 2 || er !== 1'b0 || !op) begin
            errors++; $display("FAIL abort_recover: rdata %h lat %0d err %b want %h 2 0", rd, lat, er, exp_rd);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] rd; logic er; int lat; bit cs; logic [DL2-1:0] ca; bit st, op;
        bit got[$];
        bit exp_seq[$];
        int losses;
        do_txn(1'b0, 1'b1, 32'h1014, 32'h1111_C0C0, 4'hF, 1'b0, rd, er, lat, cs, ca, st, op);
        ref_write(32'h1014, 32'h1111_C0C0, 4'hF);
        do_txn(1'b1, 1'b1, 32'h1018, 32'h2222_D0D0, 4'hF, 1'b0, rd, er, lat, cs, ca, st, op);
        ref_write(32'h1018, 32'h2222_D0D0, 4'hF);
        apply_reset();
        losses = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_seq.push_back(1'(k % 2));
`else
            if (losses >= MAXW) begin exp_seq.push_back(1'b1); losses = 0; end
            else begin exp_seq.push_back(1'b0); losses++; end
`endif
        end
        cpu_we = 1'b0; cpu_addr = 32'h1014; dbg_we = 1'b0; dbg_addr = 32'h1018;
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_busy = 1'b1; dbg_busy = 1'b1;
        for (int c = 0; c < 60 && got.size() < 10; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got.push_back(1'b0);
                checks++; if (cpu_rdata !== ref_read(5)) begin errors++; $display("FAIL arb_cpu_rdata: got %h want %h", cpu_rdata, ref_read(5)); end
            end
            if (dbg_ack) begin
                got.push_back(1'b1);
                checks++; if (dbg_rdata !== ref_read(6)) begin errors++; $display("FAIL arb_dbg_rdata: got %h want %h", dbg_rdata, ref_read(6)); end
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) @(negedge clk);
        cpu_busy = 1'b0; dbg_busy = 1'b0;
        checks++; if (got.size() < 10) begin errors++; $display("FAIL arb_count: got %0d grants want 10", got.size()); end
        for (int k = 0; k < got.size() && k < 10; k++) begin
            checks++;
            if (got[k] !== exp_seq[k]) begin
                errors++; $display("FAIL arb_grant_%0d: got port %0d want port %0d", k, got[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_ack_integrity();
        checks++; if (double_ack_cnt !== 0) begin errors++; $display("FAIL double_ack: got %0d want 0", double_ack_cnt); end
        checks++; if (spurious_cnt !== 0) begin errors++; $display("FAIL spurious_ack: got %0d want 0", spurious_cnt); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_out_of_range();
        test_random();
        test_reset_abort();
        test_arbitration();
        test_ack_integrity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
